// File: rtl/acceptor_monede.sv
// acceptor_monede: debounced coin acceptor that emits single-cycle coin pulses for automat_bauturi.
// Optional running total of accepted lei when ACCEPTOR_SUMA_EN is defined.
module acceptor_monede #(
    parameter int DEB_CYCLES = 4,
    parameter int MAX_HOLD   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       senzor_1leu,
    input  logic       senzor_5lei,
    input  logic       activ,
    output logic       B1leu,
    output logic       B5lei,
    output logic       respins,
    output logic       blocaj,
    output logic [7:0] suma
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [7:0] DEB = 8'(DEB_CYCLES);
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
    typedef enum logic [2:0] {IDLE, FILTRU, VALID, RESPINS, ELIB, BLOCAJ} state_t;
    state_t state;
    logic [1:0] s1, s2;
    logic tip5, rec, alt;
    logic [7:0] cnt;
    logic [HW-1:0] hold;
    assign rec = tip5 ? s2[1] : s2[0];
    assign alt = tip5 ? s2[0] : s2[1];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            s1 <= '0;
            s2 <= '0;
            tip5 <= 1'b0;
            cnt <= '0;
            hold <= '0;
            B1leu <= 1'b0;
            B5lei <= 1'b0;
            respins <= 1'b0;
            blocaj <= 1'b0;
        end else begin
            s1 <= {senzor_5lei, senzor_1leu};
            s2 <= s1;
            B1leu <= 1'b0;
            B5lei <= 1'b0;
            respins <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2 == 2'b11) begin
                        state <= RESPINS;
                    end else if (s2 != 2'b00) begin
                        tip5 <= s2[1];
                        cnt <= 8'd1;
                        state <= FILTRU;
                    end
                end
                FILTRU: begin
                    if (alt) state <= RESPINS;
                    else if (!rec) state <= IDLE;
                    else if (cnt + 8'd1 >= DEB) state <= VALID;
                    else cnt <= cnt + 8'd1;
                end
                VALID: begin
                    B1leu <= activ & ~tip5;
                    B5lei <= activ & tip5;
                    respins <= ~activ;
                    cnt <= '0;
                    hold <= '0;
                    state <= ELIB;
                end
                RESPINS: begin
                    respins <= 1'b1;
                    cnt <= '0;
                    hold <= '0;
                    state <= ELIB;
                end
                ELIB: begin
                    hold <= (hold == HMAX) ? hold : hold + 1'b1;
                    // any high sample restarts the low-run count; a long hold means a jammed coin
                    if (s2 != 2'b00) begin
                        cnt <= '0;
                        if (hold >= HMAX - 1'b1) begin
                            state <= BLOCAJ;
                            blocaj <= 1'b1;
                        end
                    end else if (cnt + 8'd1 >= DEB) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                BLOCAJ: blocaj <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ACCEPTOR_SUMA_EN
    logic [8:0] sum9;
    assign sum9 = {1'b0, suma} + (tip5 ? 9'd5 : 9'd1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) suma <= '0;
        else if (state == VALID && activ) suma <= sum9[8] ? 8'hFF : sum9[7:0];
    end
`else
    assign suma = 8'd0;
`endif
endmodule
